// File: rtl/sysctrl_initiator_if.sv
// Bundle of the request/response handshake and the system-control byte bus
// seen by the initiator. The master modport is the initiator side.
interface sysctrl_initiator_if #(
    parameter int MAX_LEN = 8
);
    // Request handshake: a transfer happens on a rising clk edge where
    // req_valid && req_ready; req_* must stay stable while req_valid is high
    // and req_ready is low. rsp_valid is a one-cycle pulse with no back-pressure.
    logic                 req_valid;
    logic                 req_ready;
    logic [7:0]           req_cmd;
    logic [3:0]           req_len;
    logic [8*MAX_LEN-1:0] req_data;
    logic                 rsp_valid;
    logic [8*MAX_LEN-1:0] rsp_data;
    logic [3:0]           rsp_count;
    logic                 busy;
    logic                 data_in_strobe;
    logic                 data_in_start;
    logic [7:0]           data_in;
    logic [7:0]           data_out;

    modport master (
        input  req_valid, req_cmd, req_len, req_data, data_out,
        output req_ready, rsp_valid, rsp_data, rsp_count, busy,
               data_in_strobe, data_in_start, data_in
    );

    modport slave (
        output req_valid, req_cmd, req_len, req_data, data_out,
        input  req_ready, rsp_valid, rsp_data, rsp_count, busy,
               data_in_strobe, data_in_start, data_in
    );
endinterface

// File: rtl/sysctrl_initiator.sv
// System-control bus initiator: sends a command byte plus payload as spaced
// strobes and collects the responder's reply byte for every payload strobe.
module sysctrl_initiator #(
    parameter int MAX_LEN = 8,
    parameter int GAP     = 3
) (
    input  logic                clk,
    input  logic                reset,
    sysctrl_initiator_if.master bus,
    output logic [1:0]          dbg_state
);
    if (GAP < 2) begin : g_gap_check
        $error("sysctrl_initiator: GAP must be >= 2");
    end
    if (MAX_LEN < 1 || MAX_LEN > 15) begin : g_len_check
        $error("sysctrl_initiator: MAX_LEN must be in 1..15");
    end

    localparam int         W         = 8 * MAX_LEN;
    localparam int         GW        = (GAP > 2) ? $clog2(GAP) : 1;
    localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t          state;
    logic            is_cmd;
    logic [3:0]      k;
    logic [3:0]      len_q;
    logic [W-1:0]    payload_q;
    logic [GW-1:0]   gap_cnt;
    logic            strobe_q;
    logic            start_q;
    logic [7:0]      data_in_q;
    logic            rsp_valid_q;
    logic [W-1:0]    rsp_data_q;
    logic [3:0]      rsp_count_q;
    logic            busy_q;
    logic            ready_q;

    logic            accept;
    logic [3:0]      len_clamped;
    logic            last_byte;
    logic [3:0]      next_k;

    assign accept      = bus.req_valid && ready_q;
    assign len_clamped = (bus.req_len > MAX_LEN_L) ? MAX_LEN_L : bus.req_len;
    assign last_byte   = is_cmd ? (len_q == 4'd0) : (k == len_q - 4'd1);
    assign next_k      = is_cmd ? 4'd0 : k + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            is_cmd      <= 1'b0;
            k           <= '0;
            len_q       <= '0;
            payload_q   <= '0;
            gap_cnt     <= '0;
            strobe_q    <= 1'b0;
            start_q     <= 1'b0;
            data_in_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_count_q <= '0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            strobe_q    <= 1'b0;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state)
                // DONE accepts like IDLE so back-to-back requests lose no cycle.
                IDLE, DONE: begin
                    if (accept) begin
                        len_q       <= len_clamped;
                        payload_q   <= bus.req_data;
                        rsp_data_q  <= '0;
                        rsp_count_q <= len_clamped;
                        k           <= '0;
                        is_cmd      <= 1'b1;
                        strobe_q    <= 1'b1;
                        start_q     <= 1'b1;
                        data_in_q   <= bus.req_cmd;
                        busy_q      <= 1'b1;
                        ready_q     <= 1'b0;
                        state       <= SEND;
                    end else begin
                        state <= IDLE;
                    end
                end
                SEND: begin
                    gap_cnt <= GW'(GAP - 1);
                    state   <= WAIT;
                end
                WAIT: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else begin
                        // The reply to the command byte itself carries nothing useful.
                        if (!is_cmd) rsp_data_q[8*k +: 8] <= bus.data_out;
                        if (last_byte) begin
                            rsp_valid_q <= 1'b1;
                            busy_q      <= 1'b0;
                            ready_q     <= 1'b1;
                            state       <= DONE;
                        end else begin
                            k         <= next_k;
                            is_cmd    <= 1'b0;
                            strobe_q  <= 1'b1;
                            data_in_q <= payload_q[8*next_k +: 8];
                            state     <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready      = ready_q;
    assign bus.busy           = busy_q;
    assign bus.data_in_strobe = strobe_q;
    assign bus.data_in_start  = start_q;
    assign bus.data_in        = data_in_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_data       = rsp_data_q;
    assign bus.rsp_count      = rsp_count_q;
    assign dbg_state          = state;
endmodule

// File: tb/tb_sysctrl_initiator.sv
// Bench for sysctrl_initiator with a small registered responder model; strobes
// and responses are checked against scoreboard queues filled at each request.
module tb_sysctrl_initiator;
    localparam int MAX_LEN = 8;
    localparam int GAP     = 3;
    localparam int W       = 8 * MAX_LEN;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] dbg_state;

    sysctrl_initiator_if #(.MAX_LEN(MAX_LEN)) bus();

    sysctrl_initiator #(.MAX_LEN(MAX_LEN), .GAP(GAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Scoreboard state
    logic [7:0] exp_q[$];
    logic [8:0] exp_strb_q[$];
    int         exp_lat_q[$];
    logic [3:0] exp_cnt_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int last_rsp_cyc = -100;
    int last_start_gap = 0;
    int extra_strobes = 0;
    int unexp_rsp = 0;
    int ack_cnt = 0;

    // Responder model state
    logic [7:0] r_cmd, r_key, scanlines, int_ack;
    logic [3:0] r_idx;
    logic       sys_int;
    logic       int_raise = 1'b0;
    logic       int_exp = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] status_byte(input int i);
        case (i)
            0:       return 8'h5C;
            1:       return 8'h42;
            2:       return 8'h01;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] expect_byte(input logic [7:0] cmd, input int i, input logic [7:0] b);
        case (cmd)
            8'h00:   return status_byte(i);
            8'h04:   return 8'h00;
            8'h05:   return (i == 0) ? {7'b0, int_exp} : 8'h00;
            default: return b ^ cmd ^ 8'(i);
        endcase
    endfunction

    // Registered responder: replies to payload byte i after the strobe edge.
    always @(posedge clk) begin
        if (reset) begin
            bus.data_out <= 8'h00;
            r_cmd        <= 8'h00;
            r_key        <= 8'h00;
            r_idx        <= 4'd0;
            scanlines    <= 8'h00;
            sys_int      <= 1'b0;
            int_ack      <= 8'h00;
        end else begin
            int_ack <= 8'h00;
            if (int_raise) sys_int <= 1'b1;
            if (bus.data_in_strobe) begin
                if (bus.data_in_start) begin
                    r_cmd        <= bus.data_in;
                    r_idx        <= 4'd0;
                    bus.data_out <= 8'hEE;
                end else begin
                    r_idx <= r_idx + 4'd1;
                    case (r_cmd)
                        8'h00: bus.data_out <= status_byte(int'(r_idx));
                        8'h04: begin
                            bus.data_out <= 8'h00;
                            if (r_idx == 4'd0) r_key <= bus.data_in;
                            if (r_idx == 4'd1 && r_key == 8'h53) scanlines <= bus.data_in;
                        end
                        8'h05: begin
                            bus.data_out <= (r_idx == 4'd0) ? {7'b0, sys_int} : 8'h00;
                            if (r_idx == 4'd0 && bus.data_in[0] && sys_int) begin
                                int_ack <= 8'h01;
                                sys_int <= 1'b0;
                            end
                        end
                        default: bus.data_out <= bus.data_in ^ r_cmd ^ {4'h0, r_idx};
                    endcase
                end
            end
        end
    end

    // Output monitor: pops the scoreboard on every strobe and response.
    always @(negedge clk) begin
        int         lat;
        logic [3:0] cnt;
        logic [W-1:0] word;
        cyc++;
        if (!reset) begin
            if (bus.rsp_valid) begin
                if (exp_lat_q.size() == 0) begin
                    unexp_rsp++;
                end else begin
                    lat  = exp_lat_q.pop_front();
                    cnt  = exp_cnt_q.pop_front();
                    word = '0;
                    for (int i = 0; i < int'(cnt); i++) word[8*i +: 8] = exp_q.pop_front();
                    check("rsp_latency", 64'(cyc - acc_cyc), 64'(lat));
                    check("rsp_count", 64'(bus.rsp_count), 64'(cnt));
                    check("rsp_data", 64'(bus.rsp_data), 64'(word));
                    check("rsp_busy_ready", 64'({bus.busy, bus.req_ready}), 64'(2'b01));
                end
                last_rsp_cyc = cyc;
            end
            if (bus.data_in_strobe) begin
                if (bus.data_in_start) last_start_gap = cyc - last_rsp_cyc;
                if (exp_strb_q.size() == 0) begin
                    extra_strobes++;
                end else begin
                    check("strobe", 64'({bus.data_in_start, bus.data_in}), 64'(exp_strb_q.pop_front()));
                    check("strobe_busy", 64'(bus.busy), 64'(1));
                end
            end
            if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
            if (int_ack == 8'h01) ack_cnt++;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_req_ready"}, 64'(bus.req_ready), 64'(1));
        check({tag, "_busy"}, 64'(bus.busy), 64'(0));
        check({tag, "_strobe"}, 64'(bus.data_in_strobe), 64'(0));
        check({tag, "_start"}, 64'(bus.data_in_start), 64'(0));
        check({tag, "_data_in"}, 64'(bus.data_in), 64'(0));
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
        check({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'(0));
        check({tag, "_rsp_count"}, 64'(bus.rsp_count), 64'(0));
        check({tag, "_state"}, 64'(dbg_state), 64'(0));
    endtask

    // Drives one request and pushes what the bus and response must show.
    task automatic send(input logic [7:0] cmd, input logic [3:0] len, input logic [W-1:0] pay,
                        input bit keep_valid, input bit abort);
        int lc;
        bit ok;
        lc = (len > MAX_LEN) ? MAX_LEN : int'(len);
        @(posedge clk);
        #1;
        bus.req_cmd   = cmd;
        bus.req_len   = len;
        bus.req_data  = pay;
        bus.req_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 400 && !ok; t++) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1'b1;
        end
        if (!ok) begin
            check("accept_timeout", 64'(bus.req_ready), 64'(1));
            bus.req_valid = 1'b0;
            return;
        end
        exp_strb_q.push_back({1'b1, cmd});
        for (int i = 0; i < (abort ? 2 : lc); i++) exp_strb_q.push_back({1'b0, pay[8*i +: 8]});
        if (!abort) begin
            for (int i = 0; i < lc; i++) exp_q.push_back(expect_byte(cmd, i, pay[8*i +: 8]));
            exp_cnt_q.push_back(4'(lc));
            exp_lat_q.push_back(1 + (lc + 1) * (GAP + 1));
        end
        @(posedge clk);
        #1;
        if (!keep_valid) bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int t = 0; t < 600 && (exp_lat_q.size() != 0 || exp_strb_q.size() != 0); t++) @(negedge clk);
        if (exp_lat_q.size() != 0 || exp_strb_q.size() != 0) begin
            check({tag, "_timeout"}, 64'(exp_lat_q.size() + exp_strb_q.size()), 64'(0));
            exp_q.delete();
            exp_strb_q.delete();
            exp_lat_q.delete();
            exp_cnt_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n_strb;
        bus.req_valid = 1'b0;
        bus.req_cmd   = 8'h00;
        bus.req_len   = 4'd0;
        bus.req_data  = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset("rst");

        // Status read: 5C 42 01, rsp_valid 17 cycles after accept.
        send(8'h00, 4'd3, 64'h0, 1'b0, 1'b0);
        wait_done("status");

        // Zero length: lone start strobe, rsp_data cleared on accept.
        send(8'h01, 4'd0, 64'h0, 1'b0, 1'b0);
        wait_done("zero_len");

        // Config write: 'S' then 2.
        send(8'h04, 4'd2, 64'h0253, 1'b0, 1'b0);
        wait_done("config");
        check("scanlines", 64'(scanlines), 64'(2));

        // Length above MAX_LEN is clamped.
        send(8'h33, 4'd12, {$urandom, $urandom}, 1'b0, 1'b0);
        wait_done("clamp");

        for (int r = 0; r < 4; r++) begin
            send(8'($urandom_range(16, 255)), 4'($urandom_range(0, 15)), {$urandom, $urandom}, 1'b0, 1'b0);
            wait_done("random");
        end

        // Back-to-back: second request held valid while the first runs.
        send(8'h21, 4'd2, {$urandom, $urandom}, 1'b1, 1'b0);
        send(8'h22, 4'd3, {$urandom, $urandom}, 1'b0, 1'b0);
        wait_done("b2b");
        check("b2b_gap", 64'(last_start_gap), 64'(1));

        // Reset during the WAIT after payload byte 1 of an L=4 transfer.
        send(8'h40, 4'd4, {$urandom, $urandom}, 1'b0, 1'b1);
        n_strb = 0;
        for (int t = 0; t < 100 && n_strb < 2; t++) begin
            @(negedge clk);
            if (bus.data_in_strobe && !bus.data_in_start) n_strb++;
        end
        check("abort_strobes_seen", 64'(n_strb), 64'(2));
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset("abort");
        repeat (20) @(negedge clk);
        check("abort_extra_strobes", 64'(extra_strobes), 64'(0));
        check("abort_no_rsp", 64'(unexp_rsp), 64'(0));
        exp_strb_q.delete();
        send(8'h00, 4'd3, 64'h0, 1'b0, 1'b0);
        wait_done("after_abort");

        // Interrupt read/ack, then a repeat read sees it cleared.
        @(posedge clk);
        #1 int_raise = 1'b1;
        @(posedge clk);
        #1 int_raise = 1'b0;
        int_exp = 1'b1;
        send(8'h05, 4'd1, 64'h01, 1'b0, 1'b0);
        wait_done("int_ack");
        check("int_ack_pulses", 64'(ack_cnt), 64'(1));
        int_exp = 1'b0;
        send(8'h05, 4'd1, 64'h01, 1'b0, 1'b0);
        wait_done("int_repeat");
        check("int_ack_pulses_after", 64'(ack_cnt), 64'(1));

        check("extra_strobes", 64'(extra_strobes), 64'(0));
        check("unexpected_rsp", 64'(unexp_rsp), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
